// File: rtl/aer_pkg.sv
// Shared types for the AER round-robin event arbiter.
// Handshake state encoding and the {up,down} polarity codes.
package aer_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        SEND  = 2'd2,
        ACK   = 2'd3
    } aer_state_e;

    // Polarity codes laid out as {up, down}
    localparam logic [1:0] POL_UP   = 2'b10;
    localparam logic [1:0] POL_DOWN = 2'b01;
    localparam logic [1:0] POL_NONE = 2'b00;

endpackage

// File: rtl/aer_rr_pick.sv
// Rotating priority encoder: first set bit of pend_i at or after ptr_i,
// wrapping modulo N.
module aer_rr_pick #(
    parameter  int N  = 4,
    localparam int AW = $clog2(N)
) (
    input  logic [N-1:0]  pend_i,
    input  logic [AW-1:0] ptr_i,
    output logic          found_o,
    output logic [AW-1:0] idx_o
);

    logic [AW-1:0] cand;

    // Walk offsets from far to near so the nearest pending channel wins
    always_comb begin
        found_o = |pend_i;
        idx_o   = '0;
        cand    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            cand = AW'((int'(ptr_i) + i) % N);
            if (pend_i[cand]) begin
                idx_o = cand;
            end
        end
    end

endmodule

// File: rtl/aer_rr_arbiter.sv
// N-channel AER event arbiter with round-robin fairness and start/done
// link handshake. Optional watchdog abort enabled by AER_ARB_TIMEOUT_EN.
module aer_rr_arbiter #(
    parameter  int N_CH    = 4,
    parameter  int TIMEOUT = 255,
    localparam int ADDR_W  = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_CH-1:0]   ch_up,
    input  logic [N_CH-1:0]   ch_down,
    input  logic              fs_sen,
    input  logic              fe_d,
    output logic              go,
    output logic [ADDR_W-1:0] addr,
    output logic              up,
    output logic              down,
    output logic [N_CH-1:0]   ch_ack,
    output logic              err
);

    import aer_pkg::*;

    if (N_CH < 2 || N_CH > 16 || TIMEOUT < 1) begin : g_bad_cfg
        $error("aer_rr_arbiter: unsupported N_CH or TIMEOUT");
    end

    aer_state_e        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        pol_q, pol_d;
    logic [N_CH-1:0]   pend;
    logic              found;
    logic [ADDR_W-1:0] pick_idx;
    logic [ADDR_W-1:0] ptr_nxt;
    logic              req_g;
    logic              tmo;
    logic              abort;

    assign pend = ch_up | ch_down;

    aer_rr_pick #(.N(N_CH)) u_pick (
        .pend_i  (pend),
        .ptr_i   (ptr_q),
        .found_o (found),
        .idx_o   (pick_idx)
    );

    assign ptr_nxt = (addr_q == ADDR_W'(N_CH - 1)) ? '0 : addr_q + 1'b1;
    assign req_g   = (pol_q[1] & ch_up[addr_q]) | (pol_q[0] & ch_down[addr_q]);

`ifdef AER_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Restarts on every state change so GRANT and SEND are timed separately
    always_comb begin
        cnt_d = '0;
        if ((state_q == GRANT || state_q == SEND) && state_d == state_q) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tmo = (cnt_q == CNT_W'(TIMEOUT - 1));
    assign err = abort;
`else
    assign tmo = 1'b0;
    assign err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        addr_d  = addr_q;
        pol_d   = pol_q;
        abort   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = GRANT;
                    addr_d  = pick_idx;
                    pol_d   = ch_up[pick_idx] ? POL_UP : POL_DOWN;
                end
            end
            GRANT: begin
                if (fs_sen) state_d = SEND;
                else        abort   = tmo;
            end
            SEND: begin
                if (fe_d) state_d = ACK;
                else      abort   = tmo;
            end
            ACK: begin
                if (!req_g && !fe_d) begin
                    state_d = IDLE;
                    ptr_d   = ptr_nxt;
                    pol_d   = POL_NONE;
                end
            end
        endcase
        // Aborted event still counts as served for fairness
        if (abort) begin
            state_d = IDLE;
            ptr_d   = ptr_nxt;
            pol_d   = POL_NONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            addr_q  <= '0;
            pol_q   <= POL_NONE;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            pol_q   <= pol_d;
        end
    end

    always_comb begin
        ch_ack = '0;
        if (state_q == ACK) begin
            ch_ack[addr_q] = 1'b1;
        end
    end

    assign go   = (state_q == GRANT) || (state_q == SEND);
    assign addr = addr_q;
    assign up   = pol_q[1];
    assign down = pol_q[0];

endmodule

// File: tb/tb_aer_rr_arbiter.sv
// Bench for aer_rr_arbiter: directed handshake scenarios plus random
// request traffic checked against a round-robin reference model.
module tb_aer_rr_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] m_up;
    logic [3:0] m_dn;
    logic       fs_sen;
    logic       fe_d;
    logic       go;
    logic [1:0] addr;
    logic       up;
    logic       down;
    logic [3:0] ch_ack;
    logic       err;

    int n_cmp = 0;
    int n_err = 0;
    int ref_ptr = 0;

    aer_rr_arbiter #(.N_CH(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .ch_up   (m_up),
        .ch_down (m_dn),
        .fs_sen  (fs_sen),
        .fe_d    (fe_d),
        .go      (go),
        .addr    (addr),
        .up      (up),
        .down    (down),
        .ch_ack  (ch_ack),
        .err     (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        fs_sen = 1'b0;
        fe_d   = 1'b0;
        tick();
        tick();
        reset   = 1'b0;
        ref_ptr = 0;
    endtask

    // One full event: the model picks the winner from ref_ptr onward,
    // Up before Down on the same channel.
    task automatic serve(input bit reraise, input int gdly, input int sdly);
        int  c;
        bit  pu;
        logic [31:0] onehot;
        c = -1;
        for (int k = 0; k < 4; k++) begin
            int j;
            j = (ref_ptr + k) % 4;
            if (c < 0 && (m_up[j] || m_dn[j])) c = j;
        end
        if (c < 0) return;
        pu     = m_up[c];
        onehot = 32'(1) << c;
        tick();
        chk("grant_go",   32'(go),   1);
        chk("grant_addr", 32'(addr), 32'(c));
        chk("grant_up",   32'(up),   32'(pu));
        chk("grant_down", 32'(down), 32'(!pu));
        chk("grant_ack",  32'(ch_ack), 0);
        chk("grant_err",  32'(err),  0);
        for (int d = 0; d < gdly; d++) begin
            fe_d = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) m_dn[$urandom_range(0, 3)] = 1'b1;
            tick();
            chk("wait_go",   32'(go),     1);
            chk("wait_addr", 32'(addr),   32'(c));
            chk("wait_ack",  32'(ch_ack), 0);
        end
        fe_d   = 1'b0;
        fs_sen = 1'b1;
        tick();
        chk("send_go", 32'(go), 1);
        fs_sen = 1'b0;
        for (int d = 0; d < sdly; d++) begin
            tick();
            chk("send_hold_go", 32'(go), 1);
            chk("send_hold_up", 32'(up), 32'(pu));
        end
        fe_d = 1'b1;
        tick();
        chk("ack_go",  32'(go),     0);
        chk("ack_vec", 32'(ch_ack), onehot);
        if (pu) m_up[c] = 1'b0;
        else    m_dn[c] = 1'b0;
        tick();
        chk("ack_hold_fe", 32'(ch_ack), onehot);
        fe_d = 1'b0;
        tick();
        chk("idle_ack", 32'(ch_ack), 0);
        chk("idle_go",  32'(go),     0);
        ref_ptr = (c + 1) % 4;
        if (reraise) begin
            if (pu) m_up[c] = 1'b1;
            else    m_dn[c] = 1'b1;
        end
    endtask

    task automatic drain();
        for (int g = 0; g < 40 && (m_up != 0 || m_dn != 0); g++) begin
            serve(0, 0, 0);
        end
    endtask

    initial begin
        m_up = '0;
        m_dn = '0;
        do_reset();
        chk("rst_go",   32'(go),     0);
        chk("rst_addr", 32'(addr),   0);
        chk("rst_up",   32'(up),     0);
        chk("rst_down", 32'(down),   0);
        chk("rst_ack",  32'(ch_ack), 0);
        chk("rst_err",  32'(err),    0);

        // Single Down on channel 2, then pointer sits at 3
        m_dn[2] = 1'b1;
        serve(0, 0, 0);
        m_up = 4'b1001;
        drain();

        // Two held Up channels alternate strictly
        do_reset();
        m_up = 4'b1010;
        serve(1, 0, 0);
        serve(1, 1, 1);
        serve(1, 0, 2);
        serve(1, 2, 0);
        drain();

        // Both polarities on one channel: Up first, then Down
        m_up[0] = 1'b1;
        m_dn[0] = 1'b1;
        serve(0, 0, 0);
        serve(0, 0, 0);

        // Reset in SEND clears outputs and the pointer
        m_up = 4'b0010;
        serve(0, 0, 0);
        m_up = 4'b1000;
        tick();
        chk("rs_grant_addr", 32'(addr), 3);
        fs_sen = 1'b1;
        tick();
        chk("rs_send_go", 32'(go), 1);
        fs_sen = 1'b0;
        reset  = 1'b1;
        tick();
        chk("rs_go",   32'(go),     0);
        chk("rs_ack",  32'(ch_ack), 0);
        chk("rs_addr", 32'(addr),   0);
        chk("rs_up",   32'(up),     0);
        reset   = 1'b0;
        ref_ptr = 0;
        m_up[1] = 1'b1;
        drain();

        // fs_sen and fe_d together in GRANT only reach SEND
        m_dn[3] = 1'b1;
        tick();
        chk("fsfe_go",   32'(go),   1);
        chk("fsfe_addr", 32'(addr), 3);
        chk("fsfe_down", 32'(down), 1);
        fs_sen = 1'b1;
        fe_d   = 1'b1;
        tick();
        chk("fsfe_send_go",  32'(go),     1);
        chk("fsfe_send_ack", 32'(ch_ack), 0);
        fs_sen = 1'b0;
        fe_d   = 1'b0;
        tick();
        chk("fsfe_wait_go",  32'(go),     1);
        chk("fsfe_wait_ack", 32'(ch_ack), 0);
        fe_d = 1'b1;
        tick();
        chk("fsfe_ack", 32'(ch_ack), 32'h8);
        m_dn[3] = 1'b0;
        fe_d    = 1'b0;
        tick();
        chk("fsfe_idle", 32'(ch_ack), 0);
        ref_ptr = 0;

        // Random traffic
        for (int it = 0; it < 40; it++) begin
            m_up = m_up | 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            m_dn = m_dn | 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            if (m_up == 0 && m_dn == 0) m_up[$urandom_range(0, 3)] = 1'b1;
            serve(1'($urandom_range(0, 1)), $urandom_range(0, 3),
                  $urandom_range(0, 3));
        end
        drain();
        chk("final_err", 32'(err), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
